// File: rtl/cmd_sequencer.sv
// Command-script player: issues pre-loaded words over the cmd/send_cmd handshake and
// checks each response byte against ACK_VAL under a per-command timeout.
// Optional feature macro CMDSEQ_RETRY_EN: retry a failed command up to MAX_RETRY extra times.
module cmd_sequencer #(
    parameter int                DEPTH     = 8,
    parameter int                CMD_W     = 16,
    parameter int                RESP_W    = 8,
    parameter logic [RESP_W-1:0] ACK_VAL   = 8'hA5,
    parameter int                TO_CYCLES = 2_000_000,
    parameter int                MAX_RETRY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [CMD_W-1:0]           wr_data,
    input  logic [$clog2(DEPTH+1)-1:0] num_cmds,
    input  logic                       start,
    input  logic                       abort,
    output logic [CMD_W-1:0]           cmd,
    output logic                       send_cmd,
    input  logic                       cmd_sent,
    input  logic                       resp_rdy,
    input  logic [RESP_W-1:0]          resp,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH)-1:0]   err_idx,
    output logic [$clog2(DEPTH)-1:0]   cur_idx
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NUM_W = $clog2(DEPTH + 1);
    localparam int TO_W  = $clog2(TO_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);
`ifdef CMDSEQ_RETRY_EN
    localparam int RETRY_LIMIT = MAX_RETRY;
`else
    localparam int RETRY_LIMIT = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAIL  = 3'd6
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CMD_W-1:0]   script_r [DEPTH];

    logic               rdy_q_r;
    logic               rdy_qq_r;
    logic [RESP_W-1:0]  resp_q_r;
    logic [RESP_W-1:0]  resp_hold_r;
    logic [TO_W-1:0]    to_cnt_r;
    logic [IDX_W-1:0]   cur_idx_r;
    logic [IDX_W-1:0]   last_idx_r;
    logic [RTY_W-1:0]   retry_cnt_r;
    logic [1:0]         fail_code_r;
    logic [NUM_W-1:0]   num_eff_s;

    logic               rise_s;
    logic               timeout_s;
    logic               ack_s;
    logic               last_s;
    logic               retry_ok_s;
    logic               abort_s;

    logic [CMD_W-1:0]   cmd_r,      cmd_nxt_s;
    logic               send_r,     send_nxt_s;
    logic               busy_r,     busy_nxt_s;
    logic               done_r,     done_nxt_s;
    logic               err_r,      err_nxt_s;
    logic [1:0]         code_r,     code_nxt_s;
    logic [IDX_W-1:0]   err_idx_r,  err_idx_nxt_s;

    // cmd_sent is informational only; progress never waits on it
    logic               unused_s;
    assign unused_s = cmd_sent;

    assign rise_s     = rdy_q_r & ~rdy_qq_r;
    assign timeout_s  = (to_cnt_r == TO_W'(TO_CYCLES));
    assign ack_s      = (resp_hold_r == ACK_VAL);
    assign last_s     = (cur_idx_r == last_idx_r);
    assign retry_ok_s = (retry_cnt_r != RTY_W'(RETRY_LIMIT));
    assign abort_s    = abort && (state_r != ST_IDLE);

    assign cmd      = cmd_r;
    assign send_cmd = send_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign err_code = code_r;
    assign err_idx  = err_idx_r;
    assign cur_idx  = cur_idx_r;

    // Clamp the requested command count to the script depth
    always_comb begin
        num_eff_s = num_cmds;
        if (num_cmds > NUM_W'(DEPTH)) begin
            num_eff_s = NUM_W'(DEPTH);
        end else begin
            num_eff_s = num_cmds;
        end
    end

    // Script storage, writable only while idle and deliberately untouched by reset
    always_ff @(posedge clk) begin
        if (wr_en && (state_r == ST_IDLE)) begin
            script_r[wr_addr] <= wr_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; abort overrides every transition, a response beats a timeout
    always_comb begin
        state_nxt_s = state_r;
        if (abort_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && (num_cmds != {NUM_W{1'b0}})) begin
                        state_nxt_s = ST_LOAD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LOAD:  state_nxt_s = ST_ISSUE;
                ST_ISSUE: state_nxt_s = ST_WAIT;
                ST_WAIT: begin
                    if (rise_s) begin
                        state_nxt_s = ST_CHECK;
                    end else if (timeout_s) begin
                        state_nxt_s = retry_ok_s ? ST_LOAD : ST_FAIL;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_CHECK: begin
                    if (ack_s) begin
                        state_nxt_s = last_s ? ST_DONE : ST_LOAD;
                    end else begin
                        state_nxt_s = retry_ok_s ? ST_LOAD : ST_FAIL;
                    end
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                ST_FAIL: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM output logic: next values for the registered outputs
    always_comb begin
        cmd_nxt_s     = cmd_r;
        send_nxt_s    = 1'b0;
        busy_nxt_s    = (state_nxt_s != ST_IDLE);
        done_nxt_s    = done_r;
        err_nxt_s     = err_r;
        code_nxt_s    = code_r;
        err_idx_nxt_s = err_idx_r;
        if (abort_s) begin
            err_nxt_s     = 1'b1;
            code_nxt_s    = 2'b11;
            err_idx_nxt_s = cur_idx_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        done_nxt_s    = (num_cmds == {NUM_W{1'b0}});
                        err_nxt_s     = 1'b0;
                        code_nxt_s    = 2'b00;
                        err_idx_nxt_s = {IDX_W{1'b0}};
                    end else begin
                        done_nxt_s    = done_r;
                        err_nxt_s     = err_r;
                    end
                end
                ST_LOAD:  cmd_nxt_s  = script_r[cur_idx_r];
                ST_ISSUE: send_nxt_s = 1'b1;
                ST_DONE:  done_nxt_s = 1'b1;
                ST_FAIL: begin
                    err_nxt_s     = 1'b1;
                    code_nxt_s    = fail_code_r;
                    err_idx_nxt_s = cur_idx_r;
                end
                default: send_nxt_s = 1'b0;
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_r     <= {CMD_W{1'b0}};
            send_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            code_r    <= 2'b00;
            err_idx_r <= {IDX_W{1'b0}};
        end else begin
            cmd_r     <= cmd_nxt_s;
            send_r    <= send_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            err_r     <= err_nxt_s;
            code_r    <= code_nxt_s;
            err_idx_r <= err_idx_nxt_s;
        end
    end

    // Response edge detection, timeout counting, index and retry bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q_r     <= 1'b0;
            rdy_qq_r    <= 1'b0;
            resp_q_r    <= {RESP_W{1'b0}};
            resp_hold_r <= {RESP_W{1'b0}};
            to_cnt_r    <= {TO_W{1'b0}};
            cur_idx_r   <= {IDX_W{1'b0}};
            last_idx_r  <= {IDX_W{1'b0}};
            retry_cnt_r <= {RTY_W{1'b0}};
            fail_code_r <= 2'b00;
        end else begin
            rdy_q_r  <= resp_rdy;
            rdy_qq_r <= rdy_q_r;
            resp_q_r <= resp;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cur_idx_r   <= {IDX_W{1'b0}};
                        last_idx_r  <= IDX_W'(num_eff_s - NUM_W'(1));
                        retry_cnt_r <= {RTY_W{1'b0}};
                    end
                end
                ST_ISSUE: to_cnt_r <= {TO_W{1'b0}};
                ST_WAIT: begin
                    to_cnt_r <= to_cnt_r + TO_W'(1);
                    if (rise_s) begin
                        resp_hold_r <= resp_q_r;
                    end else if (timeout_s) begin
                        fail_code_r <= 2'b10;
                        if (retry_ok_s) begin
                            retry_cnt_r <= retry_cnt_r + RTY_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (!ack_s) begin
                        fail_code_r <= 2'b01;
                        if (retry_ok_s) begin
                            retry_cnt_r <= retry_cnt_r + RTY_W'(1);
                        end
                    end else if (!last_s) begin
                        cur_idx_r   <= cur_idx_r + IDX_W'(1);
                        retry_cnt_r <= {RTY_W{1'b0}};
                    end
                end
                default: to_cnt_r <= to_cnt_r;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: handshake latency, ack/bad/timeout/abort paths,
// count clamping, write protection while busy and reset mid-playback.
module tb_cmd_sequencer;

    localparam int DEPTH     = 8;
    localparam int CMD_W     = 16;
    localparam int RESP_W    = 8;
    localparam int TO_CYCLES = 100;
    localparam int MAX_RETRY = 2;
`ifdef CMDSEQ_RETRY_EN
    localparam int ATTEMPTS  = MAX_RETRY + 1;
`else
    localparam int ATTEMPTS  = 1;
`endif
    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] BAD = 8'h5A;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [2:0]       wr_addr = 3'd0;
    logic [15:0]      wr_data = 16'h0000;
    logic [3:0]       num_cmds = 4'd0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [15:0]      cmd;
    logic             send_cmd;
    logic             cmd_sent = 1'b0;
    logic             resp_rdy = 1'b0;
    logic [7:0]       resp = 8'h00;
    logic             busy, done, err;
    logic [1:0]       err_code;
    logic [2:0]       err_idx, cur_idx;

    int checks = 0;
    int errors = 0;
    int sends  = 0;
    int base   = 0;
    logic [15:0] script [8] = '{16'h0000, 16'h4000, 16'h6001, 16'h1003,
                                16'h1004, 16'h1005, 16'h1006, 16'h1007};

    cmd_sequencer #(
        .DEPTH(DEPTH), .CMD_W(CMD_W), .RESP_W(RESP_W), .ACK_VAL(8'hA5),
        .TO_CYCLES(TO_CYCLES), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_cmds(num_cmds), .start(start), .abort(abort), .cmd(cmd),
        .send_cmd(send_cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .err_idx(err_idx), .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    // Count issue strobes on the inactive edge
    always @(negedge clk) begin
        if (send_cmd) sends <= sends + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_send(input string tag);
        int k = 0;
        while (send_cmd !== 1'b1 && k < 40) begin
            step(1);
            k++;
        end
        check(tag, {31'd0, send_cmd}, 32'd1);
    endtask

    task automatic respond(input logic [7:0] val);
        resp = val;
        resp_rdy = 1'b1;
        step(1);
        resp_rdy = 1'b0;
        resp = 8'h00;
    endtask

    task automatic play_start(input logic [3:0] n);
        num_cmds = n;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_cmd", cmd, 32'h0);
        check("rst_send", send_cmd, 32'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_done", done, 32'h0);
        check("rst_err", err, 32'h0);
        check("rst_code", err_code, 32'h0);
        check("rst_err_idx", err_idx, 32'h0);
        check("rst_cur_idx", cur_idx, 32'h0);

        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_addr = 3'(i);
            wr_data = script[i];
            step(1);
        end
        wr_en = 1'b0;

        // Three commands, all acknowledged, with exact handshake latencies
        base = sends;
        play_start(4'd3);
        check("t1_busy_n", busy, 32'h1);
        check("t1_send_n", send_cmd, 32'h0);
        step(1);
        check("t1_send_n1", send_cmd, 32'h0);
        step(1);
        check("t1_send_n2", send_cmd, 32'h1);
        check("t1_cmd0", cmd, 32'h0000);
        step(2);
        respond(ACK);
        step(3);
        check("t1_send_m3", send_cmd, 32'h0);
        step(1);
        check("t1_send_m4", send_cmd, 32'h1);
        check("t1_cmd1", cmd, 32'h4000);
        step(2);
        respond(ACK);
        wait_send("t1_wait2");
        check("t1_cmd2", cmd, 32'h6001);
        step(1);
        respond(ACK);
        step(2);
        check("t1_done_m2", done, 32'h0);
        check("t1_busy_m2", busy, 32'h1);
        step(1);
        check("t1_done_m3", done, 32'h1);
        check("t1_busy_m3", busy, 32'h0);
        check("t1_err", err, 32'h0);
        step(5);
        check("t1_sends", sends - base, 32'd3);

`ifndef CMDSEQ_RETRY_EN
        // Bad response on index 1 stops playback
        base = sends;
        play_start(4'd3);
        check("t2_done_clr", done, 32'h0);
        wait_send("t2_wait0");
        step(1);
        respond(ACK);
        wait_send("t2_wait1");
        check("t2_cmd1", cmd, 32'h4000);
        step(1);
        respond(BAD);
        step(2);
        check("t2_err_m2", err, 32'h0);
        step(1);
        check("t2_err_m3", err, 32'h1);
        check("t2_code", err_code, 32'h1);
        check("t2_err_idx", err_idx, 32'h1);
        check("t2_done", done, 32'h0);
        check("t2_busy", busy, 32'h0);
        step(10);
        check("t2_sends", sends - base, 32'd2);
`else
        // Index 0 rejected twice then accepted; playback continues to the end
        base = sends;
        play_start(4'd3);
        for (int a = 0; a < 3; a++) begin
            wait_send("t2r_wait0");
            check("t2r_cmd0", cmd, 32'h0000);
            check("t2r_idx0", cur_idx, 32'h0);
            step(1);
            respond((a < 2) ? BAD : ACK);
        end
        wait_send("t2r_wait1");
        check("t2r_cmd1", cmd, 32'h4000);
        step(1);
        respond(ACK);
        wait_send("t2r_wait2");
        check("t2r_cmd2", cmd, 32'h6001);
        step(1);
        respond(ACK);
        step(3);
        check("t2r_done", done, 32'h1);
        check("t2r_err", err, 32'h0);
        check("t2r_sends", sends - base, 32'd5);
`endif

        // No response at all: timeout fires TO_CYCLES+2 after the strobe
        base = sends;
        play_start(4'd3);
        wait_send("t3_wait0");
        for (int a = 1; a < ATTEMPTS; a++) begin
            step(102);
            check("t3_resend_pre", send_cmd, 32'h0);
            check("t3_err_retry", err, 32'h0);
            step(1);
            check("t3_resend", send_cmd, 32'h1);
        end
        step(101);
        check("t3_err_101", err, 32'h0);
        step(1);
        check("t3_err_102", err, 32'h1);
        check("t3_code", err_code, 32'h2);
        check("t3_err_idx", err_idx, 32'h0);
        step(10);
        check("t3_sends", sends - base, 32'(ATTEMPTS));
        check("t3_busy", busy, 32'h0);

        // Abort while waiting on index 2, then an empty playback
        play_start(4'd3);
        wait_send("t4_wait0");
        step(1);
        respond(ACK);
        wait_send("t4_wait1");
        step(1);
        respond(ACK);
        wait_send("t4_wait2");
        check("t4_cur_idx", cur_idx, 32'h2);
        step(2);
        check("t4_busy_pre", busy, 32'h1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("t4_err", err, 32'h1);
        check("t4_code", err_code, 32'h3);
        check("t4_err_idx", err_idx, 32'h2);
        check("t4_busy", busy, 32'h0);
        step(3);
        play_start(4'd0);
        check("t4_zero_done", done, 32'h1);
        check("t4_zero_err", err, 32'h0);
        check("t4_zero_code", err_code, 32'h0);
        check("t4_zero_busy", busy, 32'h0);

        // Over-range count clamps to DEPTH; a write while busy must be dropped
        base = sends;
        play_start(4'd15);
        for (int i = 0; i < 8; i++) begin
            wait_send("t5_wait");
            check("t5_cmd", cmd, {16'h0000, script[i]});
            if (i == 2) begin
                wr_en = 1'b1;
                wr_addr = 3'd0;
                wr_data = 16'hFFFF;
            end
            step(1);
            wr_en = 1'b0;
            respond(ACK);
        end
        step(3);
        check("t5_done", done, 32'h1);
        check("t5_sends", sends - base, 32'd8);
        check("t5_cur_idx", cur_idx, 32'h7);

        // Reset mid-wait, then a late response that must be ignored
        base = sends;
        play_start(4'd3);
        wait_send("t6_wait0");
        check("t6_ram_kept", cmd, 32'h0000);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_cmd", cmd, 32'h0);
        check("t6_send", send_cmd, 32'h0);
        check("t6_busy", busy, 32'h0);
        check("t6_done", done, 32'h0);
        check("t6_err", err, 32'h0);
        check("t6_code", err_code, 32'h0);
        check("t6_err_idx", err_idx, 32'h0);
        check("t6_cur_idx", cur_idx, 32'h0);
        step(1);
        respond(ACK);
        step(10);
        check("t6_sends", sends - base, 32'd1);
        check("t6_done_late", done, 32'h0);
        check("t6_err_late", err, 32'h0);
        check("t6_busy_late", busy, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
